adder_arch_bank: RTL and testbench

//   Registered W-bit adder computing a+b+cin with three parallel carry architectures:

---
 rtl/adder_arch_bank_pkg.sv | 14 +
 rtl/adder_arch_bank_if.sv | 38 +++
 rtl/adder_arch_bank_fa.sv | 13 +
 rtl/adder_arch_bank.sv | 176 +++++++++++++++++
 tb/tb_adder_arch_bank.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/adder_arch_bank_pkg.sv
// Shared types and default sizes for the adder architecture bank.
package adder_pkg;

    typedef enum logic [1:0] {
        ARCH_CLA  = 2'd0,
        ARCH_CSA  = 2'd1,
        ARCH_RCA  = 2'd2,
        ARCH_RSVD = 2'd3
    } arch_e;

    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_UNIT_WIDTH = 4;

endpackage

// File: rtl/adder_arch_bank_if.sv
// Operand/result bundle for adder_arch_bank.
// ADDER_OVF_EN adds the signed-overflow flag to the bundle.
interface adder_arch_bank_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  in_valid;
    logic [WORD_WIDTH-1:0] a;
    logic [WORD_WIDTH-1:0] b;
    logic                  cin;
    logic [1:0]            arch_sel;
    logic                  out_valid;
    logic [WORD_WIDTH-1:0] sum;
    logic                  cout;
    logic                  mismatch;
`ifdef ADDER_OVF_EN
    logic                  ovf;

    modport master (
        output in_valid, a, b, cin, arch_sel,
        input  out_valid, sum, cout, mismatch, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, arch_sel,
        output out_valid, sum, cout, mismatch, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, arch_sel,
        input  out_valid, sum, cout, mismatch
    );

    modport slave (
        input  in_valid, a, b, cin, arch_sel,
        output out_valid, sum, cout, mismatch
    );
`endif
endinterface

// File: rtl/adder_arch_bank_fa.sv
// Single-bit full adder shared by the ripple chain and the carry-select units.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_arch_bank.sv
// Registered adder with CLA, carry-select and ripple architectures cross-checked each cycle.
// ADDER_OVF_EN enables the registered signed-overflow output.
module adder_arch_bank
    import adder_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int UNIT_WIDTH = DEF_UNIT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_arch_bank_if.slave bus
);

    localparam int NUM_UNITS = WORD_WIDTH / UNIT_WIDTH;

    if (WORD_WIDTH < 2) begin : g_bad_word
        $error("adder_arch_bank: WORD_WIDTH must be >= 2");
    end
    if ((UNIT_WIDTH < 1) || (WORD_WIDTH % UNIT_WIDTH != 0)) begin : g_bad_unit
        $error("adder_arch_bank: WORD_WIDTH must be a multiple of UNIT_WIDTH");
    end

    logic [WORD_WIDTH-1:0] g;
    logic [WORD_WIDTH-1:0] p;

    assign g = bus.a & bus.b;
    assign p = bus.a ^ bus.b;

    // Carry-lookahead: every carry is a flat sum of generate/propagate products.
    logic [WORD_WIDTH:0]   cla_c;
    logic [WORD_WIDTH-1:0] cla_sum;

    assign cla_c[0] = bus.cin;

    for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_cla
        logic [i+1:0] terms;
        for (genvar j = 0; j <= i; j++) begin : g_term
            if (j == i) begin : g_own
                assign terms[j] = g[j];
            end else begin : g_prop
                assign terms[j] = g[j] & (&p[i:j+1]);
            end
        end
        assign terms[i+1]  = (&p[i:0]) & bus.cin;
        assign cla_c[i+1]  = |terms;
    end

    assign cla_sum = p ^ cla_c[WORD_WIDTH-1:0];

    logic [WORD_WIDTH:0]   rca_c;
    logic [WORD_WIDTH-1:0] rca_sum;

    assign rca_c[0] = bus.cin;

    for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_rca
        full_adder_cell u_fa (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (rca_c[i]),
            .s  (rca_sum[i]),
            .co (rca_c[i+1])
        );
    end

    // Carry-select: each unit precomputes both carry-in outcomes; the block carry picks one.
    logic [NUM_UNITS:0]    blk_c;
    logic [WORD_WIDTH-1:0] csa_sum;

    assign blk_c[0] = bus.cin;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_csa_unit
        logic [UNIT_WIDTH:0]   c0;
        logic [UNIT_WIDTH:0]   c1;
        logic [UNIT_WIDTH-1:0] s0;
        logic [UNIT_WIDTH-1:0] s1;

        assign c0[0] = 1'b0;
        assign c1[0] = 1'b1;

        for (genvar k = 0; k < UNIT_WIDTH; k++) begin : g_bit
            localparam int IDX = u * UNIT_WIDTH + k;

            full_adder_cell u_fa0 (
                .a  (bus.a[IDX]),
                .b  (bus.b[IDX]),
                .ci (c0[k]),
                .s  (s0[k]),
                .co (c0[k+1])
            );

            full_adder_cell u_fa1 (
                .a  (bus.a[IDX]),
                .b  (bus.b[IDX]),
                .ci (c1[k]),
                .s  (s1[k]),
                .co (c1[k+1])
            );
        end

        assign csa_sum[u*UNIT_WIDTH +: UNIT_WIDTH] = blk_c[u] ? s1 : s0;
        assign blk_c[u+1] = blk_c[u] ? c1[UNIT_WIDTH] : c0[UNIT_WIDTH];
    end

    logic [WORD_WIDTH:0] cla_res;
    logic [WORD_WIDTH:0] csa_res;
    logic [WORD_WIDTH:0] rca_res;
    logic [WORD_WIDTH:0] sel_res;
    logic                mismatch_d;
    arch_e               arch;

    assign cla_res = {cla_c[WORD_WIDTH], cla_sum};
    assign csa_res = {blk_c[NUM_UNITS], csa_sum};
    assign rca_res = {rca_c[WORD_WIDTH], rca_sum};
    assign arch    = arch_e'(bus.arch_sel);

    always_comb begin
        sel_res = cla_res;
        case (arch)
            ARCH_CSA: sel_res = csa_res;
            ARCH_RCA: sel_res = rca_res;
            default:  sel_res = cla_res;
        endcase
    end

    assign mismatch_d = (cla_res != csa_res) | (cla_res != rca_res) | (csa_res != rca_res);

    logic                  out_valid_q;
    logic [WORD_WIDTH-1:0] sum_q;
    logic                  cout_q;
    logic                  mismatch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q      <= sel_res[WORD_WIDTH-1:0];
                cout_q     <= sel_res[WORD_WIDTH];
                mismatch_q <= mismatch_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.mismatch  = mismatch_q;

`ifdef ADDER_OVF_EN
    // Carry into the MSB is recovered from the selected sum bit and the MSB operands.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = sel_res[WORD_WIDTH-1] ^ bus.a[WORD_WIDTH-1] ^ bus.b[WORD_WIDTH-1]
                 ^ sel_res[WORD_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    a_in_valid_known: assert property (
        @(posedge clk) disable iff (!rst_n) !$isunknown(bus.in_valid)
    );

endmodule

// File: tb/tb_adder_arch_bank.sv
// Scoreboard bench for adder_arch_bank (W=16, UNIT=4).
module tb_adder_arch_bank;

    logic clk;
    logic rst_n;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    adder_arch_bank_if #(.WORD_WIDTH(16)) bus ();

    adder_arch_bank #(.WORD_WIDTH(16), .UNIT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] full;
        exp_t        e;
        full   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
        return e;
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [1:0] sel, input logic [15:0] esum, input logic ecout,
                         input logic eovf);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.arch_sel = sel;
        e.sum  = esum;
        e.cout = ecout;
        e.ovf  = eovf;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every presented result is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    chk("sum", {16'd0, bus.sum}, {16'd0, e.sum});
                    chk("cout", {31'd0, bus.cout}, {31'd0, e.cout});
                    chk("mismatch", {31'd0, bus.mismatch}, 32'd0);
`ifdef ADDER_OVF_EN
                    chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
                end
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        exp_t        m;

        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        bus.arch_sel = 2'd0;

        #3;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_sum", {16'd0, bus.sum}, 32'd0);
        #9;
        rst_n = 1'b1;

        drive(16'hFFFF, 16'h0001, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0);
        drive(16'h1234, 16'h4321, 1'b1, 2'd1, 16'h5556, 1'b0, 1'b0);
        drive(16'h1234, 16'h4321, 1'b1, 2'd2, 16'h5556, 1'b0, 1'b0);
        drive(16'h7FFF, 16'h0001, 1'b0, 2'd2, 16'h8000, 1'b0, 1'b1);
        drive(16'hFFFF, 16'hFFFF, 1'b1, 2'd3, 16'hFFFF, 1'b1, 1'b0);
        drive(16'h8000, 16'h8000, 1'b0, 2'd1, 16'h0000, 1'b1, 1'b1);
        drive(16'h0F0F, 16'h00F1, 1'b0, 2'd1, 16'h1000, 1'b0, 1'b0);

        // Single pulse then idle: out_valid drops, result holds.
        drive(16'h00FF, 16'h0101, 1'b0, 2'd0, 16'h0200, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #2;
        chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("hold_sum", {16'd0, bus.sum}, 32'h0200);
        chk("hold_cout", {31'd0, bus.cout}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            m  = model(ra, rb, rc);
            for (int s = 0; s < 4; s++) begin
                drive(ra, rb, rc, 2'(s), m.sum, m.cout, m.ovf);
            end
        end

        // Mid-stream reset: a captured result is wiped immediately.
        drive(16'hABCD, 16'h1111, 1'b1, 2'd2, 16'hBCDF, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("pre_reset_out_valid", {31'd0, bus.out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, bus.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        chk("rst_mismatch", {31'd0, bus.mismatch}, 32'd0);
`ifdef ADDER_OVF_EN
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        drive(16'h0001, 16'h0002, 1'b1, 2'd0, 16'h0004, 1'b0, 1'b0);
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
